// File: rtl/gcl_pkg.sv
// GCL shared definitions: command codes, op layout, default geometry and command decode helpers
// used by the scheduler and its write scoreboard.
package gcl_pkg;

  localparam int A_SIZE   = 18;
  localparam int DQ_SIZE  = 9;
  localparam int W_SIZE   = 4 * DQ_SIZE;
  localparam int ID_WIDTH = 4;
  localparam logic [A_SIZE-1:0] ATOP = 18'h3ffff;
  localparam logic [2:0] CMD_ILLEGAL = 3'd7;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    RDA  = 3'd1,
    RDB  = 3'd2,
    WRA  = 3'd3,
    WRB  = 3'd4,
    CPAB = 3'd5,
    CPBA = 3'd6
  } gclcmd_t;

  typedef struct packed {
    gclcmd_t             cmd;
    logic [A_SIZE-1:0]   adr1;
    logic [A_SIZE-1:0]   adr2;
    logic [W_SIZE-1:0]   data;
  } gclop_t;

  // Read-type ops are the ones that return a response.
  function automatic logic cmd_reads(logic [2:0] c);
    case (c)
      RDA, RDB, CPAB, CPBA: cmd_reads = 1'b1;
      default:              cmd_reads = 1'b0;
    endcase
  endfunction

  function automatic logic cmd_rd_bank(logic [2:0] c);
    case (c)
      RDB, CPBA: cmd_rd_bank = 1'b1;
      default:   cmd_rd_bank = 1'b0;
    endcase
  endfunction

  function automatic logic cmd_writes(logic [2:0] c);
    case (c)
      WRA, WRB, CPAB, CPBA: cmd_writes = 1'b1;
      default:              cmd_writes = 1'b0;
    endcase
  endfunction

  function automatic logic cmd_wr_bank(logic [2:0] c);
    case (c)
      WRB, CPAB: cmd_wr_bank = 1'b1;
      default:   cmd_wr_bank = 1'b0;
    endcase
  endfunction

  // Copies write to adr2; plain writes use adr1.
  function automatic logic cmd_wr_adr2(logic [2:0] c);
    case (c)
      CPAB, CPBA: cmd_wr_adr2 = 1'b1;
      default:    cmd_wr_adr2 = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] gname(logic [2:0] c);
    case (c)
      NOP:     gname = "NOP ";
      RDA:     gname = "RDA ";
      RDB:     gname = "RDB ";
      WRA:     gname = "WRA ";
      WRB:     gname = "WRB ";
      CPAB:    gname = "CPAB";
      CPBA:    gname = "CPBA";
      default: gname = "ILL ";
    endcase
  endfunction

endpackage

// File: rtl/gcl_hazard_m.sv
// Three-entry write scoreboard mirroring datapath stages 0..2; shifts every clock and flags
// read-after-write hits for the two requester read ports.
module gcl_hazard_m
  import gcl_pkg::*;
#(
  parameter int A_size = A_SIZE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_vld_i,
  input  logic                  push_bank_i,
  input  logic [A_size-1:0]     push_adr_i,
  input  logic [1:0]            rd_vld_i,
  input  logic [1:0]            rd_bank_i,
  input  logic [2*A_size-1:0]   rd_adr_i,
  output logic [1:0]            hit_o
);

  logic [2:0]              vld_q;
  logic [2:0]              vld_d;
  logic [2:0]              bank_q;
  logic [2:0]              bank_d;
  logic [2:0][A_size-1:0]  adr_q;
  logic [2:0][A_size-1:0]  adr_d;

  // Next scoreboard contents: the op being issued enters entry 0, the oldest falls off.
  always_comb begin
    vld_d  = {vld_q[1:0], push_vld_i};
    bank_d = {bank_q[1:0], push_bank_i};
    adr_d  = {adr_q[1:0], push_adr_i};
  end

  // Scoreboard registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= 3'b000;
      bank_q <= 3'b000;
      adr_q  <= {(3*A_size){1'b0}};
    end else begin
      vld_q  <= vld_d;
      bank_q <= bank_d;
      adr_q  <= adr_d;
    end
  end

  // A read port hits when its (bank, addr) matches any live in-flight write.
  always_comb begin
    hit_o = 2'b00;
    for (int p = 0; p < 2; p++) begin
      for (int e = 0; e < 3; e++) begin
        hit_o[p] = hit_o[p] | (rd_vld_i[p] & vld_q[e] & (bank_q[e] == rd_bank_i[p]) &
                               (adr_q[e] == rd_adr_i[p*A_size +: A_size]));
      end
    end
  end

endmodule

// File: rtl/gcl_sched_m.sv
// GCL command scheduler: round-robin arbitration between mutator (0) and collector (1) with
// read-after-write stalls, a registered stage-0 issue port and in-order tagged read responses.
module gcl_sched_m
  import gcl_pkg::*;
#(
  parameter int                A_size  = A_SIZE,
  parameter int                DQ_size = DQ_SIZE,
  parameter logic [A_size-1:0] ATop    = ATOP,
  parameter int                ID_W    = ID_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             rq_valid,
  output logic [1:0]             rq_ready,
  input  logic [5:0]             rq_cmd,
  input  logic [2*A_size-1:0]    rq_adr1,
  input  logic [2*A_size-1:0]    rq_adr2,
  input  logic [8*DQ_size-1:0]   rq_data,
  input  logic [2*ID_W-1:0]      rq_id,
  output logic [2:0]             iss_cmd,
  output logic [A_size-1:0]      iss_adr1,
  output logic [A_size-1:0]      iss_adr2,
  output logic [4*DQ_size-1:0]   iss_data,
  output logic                   rsp_valid,
  output logic                   rsp_src,
  output logic [ID_W-1:0]        rsp_id,
  input  logic [4*DQ_size-1:0]   rsp_data,
  output logic [4*DQ_size-1:0]   rsp_rdata,
  output logic                   err
);

  localparam int W = 4 * DQ_size;

  logic [1:0][2:0]   cmd_s;
  logic [1:0]        rd_vld_s;
  logic [1:0]        rd_bank_s;
  logic [1:0]        hit_s;
  logic [1:0]        elig_s;
  logic [1:0]        gnt_s;
  logic              any_s;
  logic              sel_s;
  logic [2:0]        sel_cmd_s;
  logic [A_size-1:0] sel_adr1_s;
  logic [A_size-1:0] sel_adr2_s;
  logic [W-1:0]      sel_data_s;
  logic [ID_W-1:0]   sel_id_s;
  logic              wr_push_s;
  logic              wr_bank_s;
  logic [A_size-1:0] wr_adr_s;
  logic              rsp_push_s;

  logic              rr_q, rr_d;
  logic [2:0]        iss_cmd_q, iss_cmd_d;
  logic [A_size-1:0] iss_adr1_q, iss_adr1_d;
  logic [A_size-1:0] iss_adr2_q, iss_adr2_d;
  logic [W-1:0]      iss_data_q, iss_data_d;
  logic              err_q, err_d;
  // Response pipe stages 0..2; the rsp_* output register is the fourth stage (issue+4).
  logic [2:0]           rs_vld_q;
  logic [2:0]           rs_src_q;
  logic [2:0][ID_W-1:0] rs_id_q;
  logic                 rsp_valid_q;
  logic                 rsp_src_q;
  logic [ID_W-1:0]      rsp_id_q;
  logic [W-1:0]         rsp_rdata_q;

  // Per-requester read-port decode for the hazard check.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cmd_s[i]     = rq_cmd[3*i +: 3];
      rd_vld_s[i]  = rq_valid[i] & cmd_reads(cmd_s[i]);
      rd_bank_s[i] = cmd_rd_bank(cmd_s[i]);
    end
  end

  gcl_hazard_m #(
    .A_size (A_size)
  ) u_hazard (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_vld_i  (wr_push_s),
    .push_bank_i (wr_bank_s),
    .push_adr_i  (wr_adr_s),
    .rd_vld_i    (rd_vld_s),
    .rd_bank_i   (rd_bank_s),
    .rd_adr_i    (rq_adr1),
    .hit_o       (hit_s)
  );

  assign elig_s = rq_valid & ~hit_s;

  // Round-robin only decides a tie; a lone eligible requester always wins.
  always_comb begin
    if (elig_s == 2'b11) begin
      gnt_s = rr_q ? 2'b10 : 2'b01;
    end else begin
      gnt_s = elig_s;
    end
  end

  assign rq_ready   = gnt_s;
  assign any_s      = gnt_s[0] | gnt_s[1];
  assign sel_s      = gnt_s[1];
  assign sel_cmd_s  = sel_s ? cmd_s[1] : cmd_s[0];
  assign sel_adr1_s = sel_s ? rq_adr1[2*A_size-1:A_size] : rq_adr1[A_size-1:0];
  assign sel_adr2_s = sel_s ? rq_adr2[2*A_size-1:A_size] : rq_adr2[A_size-1:0];
  assign sel_data_s = sel_s ? rq_data[2*W-1:W] : rq_data[W-1:0];
  assign sel_id_s   = sel_s ? rq_id[2*ID_W-1:ID_W] : rq_id[ID_W-1:0];

  // Granted op becomes the next stage-0 op; illegal codes go out as NOP and raise err.
  always_comb begin
    iss_cmd_d  = NOP;
    iss_adr1_d = ATop;
    iss_adr2_d = ATop;
    iss_data_d = {W{1'b0}};
    err_d      = 1'b0;
    rr_d       = rr_q;
    if (any_s) begin
      rr_d = ~sel_s;
      if (sel_cmd_s == CMD_ILLEGAL) begin
        err_d = 1'b1;
      end else begin
        iss_cmd_d  = sel_cmd_s;
        iss_adr1_d = sel_adr1_s;
        iss_adr2_d = sel_adr2_s;
        iss_data_d = sel_data_s;
      end
    end else begin
      rr_d = rr_q;
    end
  end

  assign wr_push_s  = any_s & cmd_writes(sel_cmd_s);
  assign wr_bank_s  = cmd_wr_bank(sel_cmd_s);
  assign wr_adr_s   = cmd_wr_adr2(sel_cmd_s) ? sel_adr2_s : sel_adr1_s;
  assign rsp_push_s = any_s & cmd_reads(sel_cmd_s);

  // Issue register, rr pointer, response pipe and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q        <= 1'b0;
      iss_cmd_q   <= NOP;
      iss_adr1_q  <= ATop;
      iss_adr2_q  <= ATop;
      iss_data_q  <= {W{1'b0}};
      err_q       <= 1'b0;
      rs_vld_q    <= 3'b000;
      rs_src_q    <= 3'b000;
      rs_id_q     <= {(3*ID_W){1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_src_q   <= 1'b0;
      rsp_id_q    <= {ID_W{1'b0}};
      rsp_rdata_q <= {W{1'b0}};
    end else begin
      rr_q        <= rr_d;
      iss_cmd_q   <= iss_cmd_d;
      iss_adr1_q  <= iss_adr1_d;
      iss_adr2_q  <= iss_adr2_d;
      iss_data_q  <= iss_data_d;
      err_q       <= err_d;
      rs_vld_q    <= {rs_vld_q[1:0], rsp_push_s};
      rs_src_q    <= {rs_src_q[1:0], sel_s};
      rs_id_q     <= {rs_id_q[1:0], sel_id_s};
      rsp_valid_q <= rs_vld_q[2];
      rsp_src_q   <= rs_src_q[2];
      rsp_id_q    <= rs_id_q[2];
      if (rs_vld_q[2]) begin
        rsp_rdata_q <= rsp_data;
      end else begin
        rsp_rdata_q <= rsp_rdata_q;
      end
    end
  end

  assign iss_cmd   = iss_cmd_q;
  assign iss_adr1  = iss_adr1_q;
  assign iss_adr2  = iss_adr2_q;
  assign iss_data  = iss_data_q;
  assign err       = err_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_src   = rsp_src_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
